lsu_req: RTL and testbench
==========================

# lsu_req

Load/store request initiator between the EX stage and the data-memory responder. It accepts one memory operation per instruction from EX and converts its size and offset into an aligned 64-bit request with byte strobes. It stalls the pipeline until the responder answers, then returns sign- or zero-extended load data and a fault code toward MEM/WB. It is the requesting end of the data-memory valid/ready interface.

## Interface
- TIMEOUT, 255: cycles in REQ+WAIT before the operation is aborted with a timeout fault; TIMEOUT ≥ 2.
- TO_W, 8: timeout counter width; 2^TO_W > TIMEOUT.
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX holds a valid instruction.
- ex_memread / ex_memwrite  in  1 each  load / store; never both high.
- ex_funct3  in  3  0 LB/SB, 1 LH/SH, 2 LW/SW, 3 LD/SD, 4 LBU, 5 LHU, 6 LWU, 7 illegal.
- ex_addr  in  64  effective byte address.
- ex_wdata  in  64  store data, LSB-aligned.
- flush  in  1  kill the current operation.
- lsu_stall  out  1  hold EX; combinational.
- wb_valid  out  1  one-cycle completion pulse.
- wb_rdata  out  64  extended load data; 0 for stores and faults.
- lsu_fault  out  1  completion carries a fault.
- fault_cause  out  2  01 misaligned/illegal, 10 bus error, 11 timeout.
- mem_req_valid / mem_req_ready  out / in  1  request handshake.
- mem_req_we  out  1  store.
- mem_req_addr  out  64  ex_addr & ~7.
- mem_req_wdata  out  64  ex_wdata << (8*ex_addr[2:0]).
- mem_req_wstrb  out  8  byte enables; 0 for loads.
- mem_rsp_valid  in  1  response strobe.
- mem_rsp_rdata  in  64  read data.
- mem_rsp_err  in  1  access error.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- In IDLE, `go = ex_valid & (ex_memread | ex_memwrite) & ~flush`.
  - If go and the access is misaligned or funct3 is 7: go to DONE with fault 01. No memory request is issued.
  - Otherwise: latch the request and go to REQ.
- Alignment rule: a half needs addr[0]=0; a word needs addr[1:0]=0; a dword needs addr[2:0]=0.
- Strobes: byte 8'h01<<off; half 8'h03<<off; word 8'h0F<<off; dword 8'hFF. off = addr[2:0].
- REQ: mem_req_valid=1 and the request fields are held stable. On mem_req_ready, go to WAIT. mem_rsp_valid is ignored in REQ.
- WAIT: on mem_rsp_valid, go to DONE.
  - Fault 10 if mem_rsp_err.
  - Otherwise, for loads, wb_rdata = extend((rdata >> 8*off), funct3).
  - Stores produce no read data.
- Timeout counter: cleared on entry to REQ, incremented each cycle in REQ/WAIT. When it reaches TIMEOUT without completion, go to DONE with fault 11 and drop mem_req_valid. A later stray response is ignored in IDLE.
- DONE: wb_valid=1 for one cycle, then IDLE.
- wb_rdata, lsu_fault and fault_cause are registered. They hold until the next DONE.
- Flush:
  - In IDLE or REQ (before the handshake): return to IDLE, no wb_valid.
  - In WAIT: go to DRAIN. DRAIN waits for mem_rsp_valid or timeout, discards the result, then goes to IDLE.
  - In DONE: wb_valid is suppressed.
- Reset values:
  - State IDLE.
  - All outputs 0: lsu_stall, wb_valid, wb_rdata, lsu_fault, fault_cause, mem_req_*.
  - Timeout counter 0.
- Reset mid-operation: the request is abandoned immediately. The responder is reset by the same rstn.

## Timing
- `lsu_stall = (IDLE & go) | REQ | WAIT | DRAIN`. lsu_stall is low in DONE, so EX advances at the end of the DONE cycle.
- Minimum latency: go at cycle 0, REQ with ready at cycle 1, response at cycle 2, wb_valid at cycle 3. Stall is high in cycles 0–2.
- Misaligned access: go at cycle 0, wb_valid with fault at cycle 1.
- Back-to-back operations: IDLE accepts the next go the cycle after DONE.
- mem_req_valid must not drop before ready, except on flush or timeout.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses fault with 01 as described above.
- Undefined: offset bits below the access size are forced to zero (natural alignment down), and the access proceeds normally. funct3=7 still faults with 01.

## Test plan
- LB at addr 0x13, rsp_rdata 0x0000_0000_8000_0000, immediate ready and 1-cycle response → wb_valid at cycle 3, wb_rdata 0xFFFF_FFFF_FFFF_FF80, stall high for 3 cycles.
- SH at 0x0A, wdata 0x1234 → mem_req_addr 0x08, wstrb 0x0C, wdata 0x0000_0000_1234_0000, we=1; wb_valid with wb_rdata 0.
- LW at 0x06 → with macro: fault 01 at cycle 1, no mem_req_valid. Without macro: request at 0x00 with off 4, LW data from bytes 4–7.
- mem_req_ready held low for 255 cycles → fault 11, mem_req_valid drops, return to IDLE; a response at cycle 300 is ignored.
- LD accepted, flush in WAIT, response 2 cycles later with err=1 → no wb_valid, stall high until the response, then IDLE.
- rstn asserted in WAIT → all outputs 0 asynchronously; after release, an LBU at 0x1 with rdata 0xFF00 → wb_rdata 0xFF.

Source files
------------

// File: rtl/lsu_req.sv
// lsu_req: load/store request initiator between EX and the data-memory responder.
// Turns one EX memory operation into an aligned 64-bit valid/ready request with
// byte strobes, stalls EX until the response, and returns extended load data
// plus a fault code.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined: misaligned accesses
// fault with cause 01; undefined: offsets are aligned down to the access size).
module lsu_req #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [2:0]  ex_funct3,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic        flush,
  output logic        lsu_stall,
  output logic        wb_valid,
  output logic [63:0] wb_rdata,
  output logic        lsu_fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_we,
  output logic [63:0] mem_req_addr,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_rdata,
  input  logic        mem_rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_BUSERR   = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;

  state_t          r_state;
  state_t          w_next;

  logic [TO_W-1:0] r_to;
  logic            w_to_hit;

  // latched request
  logic            r_we;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [7:0]      r_wstrb;
  logic [2:0]      r_off;
  logic [2:0]      r_funct3;

  // registered completion result
  logic [63:0]     r_rdata;
  logic            r_fault;
  logic [1:0]      r_cause;

  // decode of the incoming EX operation
  logic            w_go;
  logic            w_illegal;
  logic            w_dec_fault;
  logic [1:0]      w_size;
  logic [2:0]      w_off;
  logic [7:0]      w_strb;
  logic [63:0]     w_wdata_sh;
  logic [63:0]     w_rsp_sh;

  // next-state side outputs
  logic            w_done_load;
  logic            w_res_fault;
  logic [1:0]      w_res_cause;
  logic [63:0]     w_res_data;

  function automatic logic [63:0] extend(input logic [63:0] d, input logic [2:0] f);
    logic [63:0] res;
    res = '0;
    case (f)
      3'd0:    res = {{56{d[7]}},  d[7:0]};
      3'd1:    res = {{48{d[15]}}, d[15:0]};
      3'd2:    res = {{32{d[31]}}, d[31:0]};
      3'd3:    res = d;
      3'd4:    res = {56'b0, d[7:0]};
      3'd5:    res = {48'b0, d[15:0]};
      3'd6:    res = {32'b0, d[31:0]};
      default: res = '0;
    endcase
    return res;
  endfunction

  assign w_go      = ex_valid & (ex_memread | ex_memwrite) & ~flush;
  assign w_illegal = (ex_funct3 == 3'd7);
  assign w_size    = ex_funct3[1:0];
  assign w_to_hit  = (r_to >= TO_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misal;

  // misalignment check against the natural size of the access
  always_comb begin
    w_misal = 1'b0;
    case (w_size)
      2'd0: w_misal = 1'b0;
      2'd1: w_misal = ex_addr[0];
      2'd2: w_misal = |ex_addr[1:0];
      2'd3: w_misal = |ex_addr[2:0];
      default: w_misal = 1'b0;
    endcase
  end

  assign w_off       = ex_addr[2:0];
  assign w_dec_fault = w_illegal | w_misal;
`else
  // offset bits below the access size are dropped (align down)
  always_comb begin
    w_off = ex_addr[2:0];
    case (w_size)
      2'd0: w_off = ex_addr[2:0];
      2'd1: w_off = {ex_addr[2:1], 1'b0};
      2'd2: w_off = {ex_addr[2], 2'b00};
      2'd3: w_off = 3'b000;
      default: w_off = ex_addr[2:0];
    endcase
  end

  assign w_dec_fault = w_illegal;
`endif

  // byte strobes for stores; loads carry no strobes
  always_comb begin
    w_strb = '0;
    if (ex_memwrite) begin
      case (w_size)
        2'd0: w_strb = 8'h01 << w_off;
        2'd1: w_strb = 8'h03 << w_off;
        2'd2: w_strb = 8'h0F << w_off;
        2'd3: w_strb = 8'hFF;
        default: w_strb = '0;
      endcase
    end
  end

  assign w_wdata_sh = ex_wdata << {w_off, 3'b000};
  assign w_rsp_sh   = mem_rsp_rdata >> {r_off, 3'b000};

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // next-state logic and completion result selection
  always_comb begin
    w_next      = r_state;
    w_done_load = 1'b0;
    w_res_fault = 1'b0;
    w_res_cause = 2'b00;
    w_res_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          if (w_dec_fault) begin
            w_next      = S_DONE;
            w_done_load = 1'b1;
            w_res_fault = 1'b1;
            w_res_cause = C_MISALIGN;
          end else begin
            w_next = S_REQ;
          end
        end
      end
      S_REQ: begin
        // a flush that coincides with the handshake still owes a response
        if (flush) begin
          w_next = mem_req_ready ? S_DRAIN : S_IDLE;
        end else if (mem_req_ready) begin
          w_next = S_WAIT;
        end else if (w_to_hit) begin
          w_next      = S_DONE;
          w_done_load = 1'b1;
          w_res_fault = 1'b1;
          w_res_cause = C_TIMEOUT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (flush) begin
            w_next = S_IDLE;
          end else begin
            w_next      = S_DONE;
            w_done_load = 1'b1;
            if (mem_rsp_err) begin
              w_res_fault = 1'b1;
              w_res_cause = C_BUSERR;
            end else if (!r_we) begin
              w_res_data = extend(w_rsp_sh, r_funct3);
            end
          end
        end else if (flush) begin
          w_next = S_DRAIN;
        end else if (w_to_hit) begin
          w_next      = S_DONE;
          w_done_load = 1'b1;
          w_res_fault = 1'b1;
          w_res_cause = C_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid || w_to_hit) w_next = S_IDLE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // timeout counter: cleared on entry to REQ, counts in REQ/WAIT/DRAIN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_next == S_REQ) r_to <= '0;
    end else if (r_state == S_REQ || r_state == S_WAIT || r_state == S_DRAIN) begin
      r_to <= r_to + 1'b1;
    end
  end

  // latch the request fields when an operation is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_off    <= '0;
      r_funct3 <= '0;
    end else if (r_state == S_IDLE && w_next == S_REQ) begin
      r_we     <= ex_memwrite;
      r_addr   <= {ex_addr[63:3], 3'b000};
      r_wdata  <= ex_memwrite ? w_wdata_sh : '0;
      r_wstrb  <= w_strb;
      r_off    <= w_off;
      r_funct3 <= ex_funct3;
    end
  end

  // completion result, held until the next completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
    end else if (w_done_load) begin
      r_rdata <= w_res_data;
      r_fault <= w_res_fault;
      r_cause <= w_res_cause;
    end
  end

  // rstn gates the stall so it reads 0 while reset is asserted even with EX active
  assign lsu_stall     = rstn & (((r_state == S_IDLE) & w_go) | (r_state == S_REQ) |
                                 (r_state == S_WAIT) | (r_state == S_DRAIN));
  assign wb_valid      = (r_state == S_DONE) & ~flush;
  assign wb_rdata      = r_rdata;
  assign lsu_fault     = r_fault;
  assign fault_cause   = r_cause;
  assign mem_req_valid = (r_state == S_REQ);
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign mem_req_wstrb = r_wstrb;

endmodule

// File: tb/tb_lsu_req.sv
// Directed testbench for lsu_req: hand-computed vectors, one linear sequence.
module tb_lsu_req;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_memread, ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [63:0] ex_addr, ex_wdata;
  logic        flush;
  logic        lsu_stall, wb_valid, lsu_fault;
  logic [63:0] wb_rdata;
  logic [1:0]  fault_cause;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [63:0] mem_rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_req #(.TIMEOUT(255), .TO_W(8)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .ex_valid      (ex_valid),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_funct3     (ex_funct3),
    .ex_addr       (ex_addr),
    .ex_wdata      (ex_wdata),
    .flush         (flush),
    .lsu_stall     (lsu_stall),
    .wb_valid      (wb_valid),
    .wb_rdata      (wb_rdata),
    .lsu_fault     (lsu_fault),
    .fault_cause   (fault_cause),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    ex_valid    = 1'b1;
    ex_memread  = rd;
    ex_memwrite = wr;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = wd;
  endtask

  task automatic ex_idle;
    ex_valid    = 1'b0;
    ex_memread  = 1'b0;
    ex_memwrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_memwrite = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_rdata = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", lsu_stall, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_rdata", wb_rdata, 0);
    chk("rst_cause", fault_cause, 0);
    chk("rst_reqv", mem_req_valid, 0);
    chk("rst_strb", mem_req_wstrb, 0);
    #3 rstn = 1'b1;
    tick;

    // LB at 0x13, immediate ready, 1-cycle response
    issue(1, 0, 3'd0, 64'h13, 0);
    mem_req_ready = 1'b1;
    #1;
    chk("lb_c0_stall", lsu_stall, 1);
    chk("lb_c0_reqv", mem_req_valid, 0);
    tick;
    chk("lb_c1_stall", lsu_stall, 1);
    chk("lb_c1_reqv", mem_req_valid, 1);
    chk("lb_c1_addr", mem_req_addr, 64'h10);
    chk("lb_c1_we", mem_req_we, 0);
    chk("lb_c1_strb", mem_req_wstrb, 0);
    tick;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h0000_0000_8000_0000;
    chk("lb_c2_stall", lsu_stall, 1);
    chk("lb_c2_reqv", mem_req_valid, 0);
    chk("lb_c2_wbv", wb_valid, 0);
    tick;
    mem_rsp_valid = 1'b0;
    chk("lb_c3_wbv", wb_valid, 1);
    chk("lb_c3_rdata", wb_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_c3_fault", lsu_fault, 0);
    chk("lb_c3_stall", lsu_stall, 0);
    ex_idle;
    tick;
    chk("lb_c4_wbv", wb_valid, 0);
    chk("lb_c4_hold", wb_rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // SH at 0x0A, back-to-back with the previous completion
    issue(0, 1, 3'd1, 64'h0A, 64'h1234);
    mem_req_ready = 1'b1;
    #1;
    chk("sh_c0_stall", lsu_stall, 1);
    tick;
    chk("sh_reqv", mem_req_valid, 1);
    chk("sh_addr", mem_req_addr, 64'h08);
    chk("sh_strb", mem_req_wstrb, 8'h0C);
    chk("sh_wdata", mem_req_wdata, 64'h0000_0000_1234_0000);
    chk("sh_we", mem_req_we, 1);
    tick;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD_BEEF;
    tick;
    mem_rsp_valid = 1'b0;
    chk("sh_wbv", wb_valid, 1);
    chk("sh_rdata", wb_rdata, 0);
    chk("sh_fault", lsu_fault, 0);
    ex_idle;
    tick;

    // LW at 0x06
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 0, 3'd2, 64'h06, 0);
    #1;
    chk("lw_c0_stall", lsu_stall, 1);
    chk("lw_c0_reqv", mem_req_valid, 0);
    tick;
    chk("lw_wbv", wb_valid, 1);
    chk("lw_fault", lsu_fault, 1);
    chk("lw_cause", fault_cause, 2'b01);
    chk("lw_rdata", wb_rdata, 0);
    chk("lw_reqv", mem_req_valid, 0);
    ex_idle;
    tick;
`else
    issue(1, 0, 3'd2, 64'h06, 0);
    mem_req_ready = 1'b1;
    tick;
    chk("lw_reqv", mem_req_valid, 1);
    chk("lw_addr", mem_req_addr, 64'h00);
    chk("lw_strb", mem_req_wstrb, 0);
    tick;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h89AB_CDEF_0123_4567;
    tick;
    mem_rsp_valid = 1'b0;
    chk("lw_wbv", wb_valid, 1);
    chk("lw_rdata", wb_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    chk("lw_fault", lsu_fault, 0);
    ex_idle;
    tick;
`endif

    // funct3 = 7 faults in every build
    issue(1, 0, 3'd7, 64'h10, 0);
    #1;
    chk("ill_c0_stall", lsu_stall, 1);
    chk("ill_c0_reqv", mem_req_valid, 0);
    tick;
    chk("ill_wbv", wb_valid, 1);
    chk("ill_fault", lsu_fault, 1);
    chk("ill_cause", fault_cause, 2'b01);
    ex_idle;
    tick;

    // timeout: ready held low
    issue(1, 0, 3'd1, 64'h20, 0);
    mem_req_ready = 1'b0;
    tick;                       // cycle 1, REQ
    repeat (254) tick;          // cycle 255
    chk("to_c255_reqv", mem_req_valid, 1);
    chk("to_c255_wbv", wb_valid, 0);
    tick;                       // cycle 256
    chk("to_wbv", wb_valid, 1);
    chk("to_fault", lsu_fault, 1);
    chk("to_cause", fault_cause, 2'b11);
    chk("to_reqv", mem_req_valid, 0);
    chk("to_stall", lsu_stall, 0);
    ex_idle;
    tick;                       // cycle 257
    chk("to_idle_stall", lsu_stall, 0);
    repeat (43) tick;           // cycle 300
    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b0; mem_rsp_rdata = 64'hFFFF;
    #1;
    chk("stray_stall", lsu_stall, 0);
    tick;
    mem_rsp_valid = 1'b0;
    chk("stray_wbv", wb_valid, 0);
    chk("stray_cause", fault_cause, 2'b11);
    chk("stray_rdata", wb_rdata, 0);

    // flush in WAIT, response 2 cycles later with error
    issue(1, 0, 3'd3, 64'h20, 0);
    mem_req_ready = 1'b1;
    tick;                       // REQ
    tick;                       // WAIT
    mem_req_ready = 1'b0;
    flush = 1'b1;
    ex_idle;
    #1;
    chk("fl_wait_stall", lsu_stall, 1);
    tick;                       // DRAIN
    flush = 1'b0;
    chk("fl_drain_stall", lsu_stall, 1);
    chk("fl_drain_wbv", wb_valid, 0);
    tick;
    mem_rsp_valid = 1'b1; mem_rsp_err = 1'b1;
    #1;
    chk("fl_rsp_stall", lsu_stall, 1);
    tick;
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    chk("fl_end_stall", lsu_stall, 0);
    chk("fl_end_wbv", wb_valid, 0);
    chk("fl_end_cause", fault_cause, 2'b11);
    tick;
    chk("fl_idle_wbv", wb_valid, 0);

    // reset asserted in WAIT
    issue(0, 1, 3'd3, 64'h48, 64'h1122_3344_5566_7788);
    mem_req_ready = 1'b1;
    tick;
    chk("rw_strb", mem_req_wstrb, 8'hFF);
    tick;                       // WAIT
    mem_req_ready = 1'b0;
    ex_idle;
    #2 rstn = 1'b0;
    #1;
    chk("rw_stall", lsu_stall, 0);
    chk("rw_wbv", wb_valid, 0);
    chk("rw_fault", lsu_fault, 0);
    chk("rw_cause", fault_cause, 0);
    chk("rw_reqv", mem_req_valid, 0);
    chk("rw_we", mem_req_we, 0);
    chk("rw_addr", mem_req_addr, 0);
    chk("rw_wdata", mem_req_wdata, 0);
    chk("rw_wstrb", mem_req_wstrb, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick;

    // LBU at 0x1 after reset release
    issue(1, 0, 3'd4, 64'h1, 0);
    mem_req_ready = 1'b1;
    tick;
    chk("lbu_addr", mem_req_addr, 0);
    chk("lbu_reqv", mem_req_valid, 1);
    tick;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFF00;
    tick;
    mem_rsp_valid = 1'b0;
    chk("lbu_wbv", wb_valid, 1);
    chk("lbu_rdata", wb_rdata, 64'hFF);
    chk("lbu_fault", lsu_fault, 0);
    ex_idle;
    tick;
    chk("lbu_idle_wbv", wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
